// File: rtl/tcm_req_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : tcm_req_bridge_if
//  Purpose  : Bundles the request channel, the response channel and the
//             single-port TCM SRAM signals of the TCM request bridge.
//  Modports : master - bridge view (takes requests, returns responses,
//                      drives the TCM)
//             slave  - environment view (requester, response consumer
//                      and TCM memory)
//  Signals  : req_valid_i/req_ready_o/req_addr_i/req_we_i/req_be_i/
//             req_wdata_i, rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_err_o,
//             tcm_en_o/tcm_addr_o/tcm_wdata_o/tcm_we_o/tcm_be_o/tcm_rdata_i
//             (suffixes are relative to the bridge)
//  Revision : 1.0 - initial release
// ============================================================================
interface tcm_req_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic                    req_we_i;
    logic [DATA_WIDTH/8-1:0] req_be_i;
    logic [DATA_WIDTH-1:0]   req_wdata_i;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;

    logic                    tcm_en_o;
    logic [ADDR_WIDTH-1:0]   tcm_addr_o;
    logic [DATA_WIDTH-1:0]   tcm_wdata_o;
    logic                    tcm_we_o;
    logic [DATA_WIDTH/8-1:0] tcm_be_o;
    logic [DATA_WIDTH-1:0]   tcm_rdata_i;

    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output tcm_en_o, tcm_addr_o, tcm_wdata_o, tcm_we_o, tcm_be_o,
        input  tcm_rdata_i
    );

    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  tcm_en_o, tcm_addr_o, tcm_wdata_o, tcm_we_o, tcm_be_o,
        output tcm_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/tcm_req_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tcm_req_bridge
//  Purpose  : Initiator-side bridge from a valid/ready request channel to a
//             single-port TCM with fixed one-cycle read latency. Responses
//             are returned in order through a bypassable 2-entry FIFO;
//             misaligned requests get an error response and never reach
//             the TCM.
//  Ports    : clk_i - clock, rising edge
//             rst_i - synchronous active-high reset
//             bus   - tcm_req_bridge_if.master (request, response, TCM)
//  Revision : 1.0 - initial release
// ============================================================================
module tcm_req_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    tcm_req_bridge_if.master   bus
);
    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_OFF_W = $clog2(c_BE_W);

    // In-flight stage: the request accepted in the previous cycle
    logic r_inf_valid;
    logic r_inf_read;
    logic r_inf_err;

    // Response FIFO: two entries, 1-bit pointers wrap naturally
    logic [DATA_WIDTH-1:0] r_fifo_rdata [2];
    logic                  r_fifo_err   [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_cnt;

    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_tcm_access;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_res_rdata;
    logic                  w_res_err;
    logic                  w_push;
    logic                  w_pop;

    generate
        if (c_OFF_W > 0) begin : g_align_chk
            assign w_misaligned = |bus.req_addr_i[c_OFF_W-1:0];
            assign w_word_addr  = {bus.req_addr_i[ADDR_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};
        end else begin : g_no_align_chk
            assign w_misaligned = 1'b0;
            assign w_word_addr  = bus.req_addr_i;
        end
    endgenerate

    // Credits come from registered state only, so a response that cannot
    // be consumed always has a FIFO slot waiting for it.
    assign w_req_ready  = !rst_i && (({1'b0, r_cnt} + {2'b00, r_inf_valid}) < 3'd2);
    assign w_accept     = bus.req_valid_i && w_req_ready;
    assign w_tcm_access = w_accept && !w_misaligned;

    assign bus.req_ready_o = w_req_ready;
    assign bus.tcm_en_o    = w_tcm_access;
    assign bus.tcm_addr_o  = w_word_addr;
    assign bus.tcm_wdata_o = bus.req_wdata_i;
    assign bus.tcm_we_o    = w_tcm_access && bus.req_we_i;
    assign bus.tcm_be_o    = !w_tcm_access ? '0 :
                             (bus.req_we_i ? bus.req_be_i : {c_BE_W{1'b1}});

    // Resolving response: TCM read data is valid only in this cycle
    assign w_res_rdata = (r_inf_valid && r_inf_read) ? bus.tcm_rdata_i : '0;
    assign w_res_err   = r_inf_valid && r_inf_err;

    assign w_fifo_empty = (r_cnt == 2'd0);

    // Head of FIFO has priority; the in-flight response bypasses only when
    // the FIFO is empty, which keeps responses in order.
    assign bus.rsp_valid_o = !rst_i && (!w_fifo_empty || r_inf_valid);
    assign bus.rsp_rdata_o = rst_i ? '0 : (w_fifo_empty ? w_res_rdata : r_fifo_rdata[r_rd_ptr]);
    assign bus.rsp_err_o   = !rst_i && (w_fifo_empty ? w_res_err : r_fifo_err[r_rd_ptr]);

    assign w_pop  = !w_fifo_empty && bus.rsp_ready_i;
    assign w_push = r_inf_valid && !(w_fifo_empty && bus.rsp_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inf_valid <= 1'b0;
            r_inf_read  <= 1'b0;
            r_inf_err   <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_rdata[i] <= '0;
                r_fifo_err[i]   <= 1'b0;
            end
        end else begin
            r_inf_valid <= w_accept;
            r_inf_read  <= w_tcm_access && !bus.req_we_i;
            r_inf_err   <= w_accept && w_misaligned;
            if (w_push) begin
                r_fifo_rdata[r_wr_ptr] <= w_res_rdata;
                r_fifo_err[r_wr_ptr]   <= w_res_err;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
`default_nettype wire
